// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter: FSM encodings, owner codes
// and default bus widths.
package cpu_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Counter width able to hold 0..max_streak inclusive.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Winner selection for the memory port: data by default, fetch when alone or
// when the data streak has reached its limit. Holds the registered streak count.
module arb_prio_sel
    import cpu_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic if_req,
    input  logic if_block,
    input  logic d_req,
    output logic if_win,
    output logic d_win
);

    localparam int SW = streak_width(MAX_D_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;
    logic          at_limit;
    logic          if_cand;

    always_comb begin
        at_limit = (streak == STREAK_MAX);
        if_cand  = if_req && !if_block;
        if_win   = en && if_cand && (!d_req || at_limit);
        d_win    = en && d_req && !(if_cand && at_limit);
    end

    // The streak only counts data grants that made a pending fetch wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (if_win || (d_win && !if_req)) begin
            streak <= '0;
        end else if (d_win && !at_limit) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction
// at a time. Define MEM_ARB_PERF_EN to add the perf_if_wait/perf_d_wait counters.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_d_wait
`endif
);

    logic [1:0] state;
    logic       owner;
    logic       drop;
    logic       grant_en;
    logic       if_win;
    logic       d_win;
    logic       flush_own;
    logic       resp_ok;

    // Grants are combinational but forced low while reset is asserted.
    assign grant_en  = reset && (state == ST_IDLE);
    assign flush_own = if_flush && (owner == OWN_IF);

    arb_prio_sel #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_sel (
        .clk      (clk),
        .reset    (reset),
        .en       (grant_en),
        .if_req   (if_req),
        .if_block (if_flush),
        .d_req    (d_req),
        .if_win   (if_win),
        .d_win    (d_win)
    );

    assign if_gnt = if_win;
    assign d_gnt  = d_win;

    // The mem_* outputs are the payload registers themselves, so the memory
    // side only ever sees clean registered values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (if_win) begin
                        state     <= ST_REQ;
                        owner     <= OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end else if (d_win) begin
                        state     <= ST_REQ;
                        owner     <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                    end
                end
                ST_REQ: begin
                    if (flush_own && !mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_WAIT;
                        if (flush_own) drop <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (flush_own) drop <= 1'b1;
                    if (mem_rvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A flush arriving in the response cycle itself also suppresses fetch data.
    always_comb begin
        resp_ok   = (state == ST_WAIT) && mem_rvalid;
        if_rvalid = resp_ok && (owner == OWN_IF) && !drop && !if_flush;
        d_rvalid  = resp_ok && (owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_req && !if_gnt) perf_if_wait <= perf_if_wait + 32'd1;
            if (d_req && !d_gnt)   perf_d_wait  <= perf_d_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference
// model and a small memory model on the memory side.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, d_req, d_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [BW-1:0] d_be;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_if_wait, perf_d_wait;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] memArr [16];
    logic [31:0] refMem [16];
    int          rvDelay;
    logic [31:0] memRd;

    int          streak;
    bit          busy, waitGnt, waitRv, ownIf, drop;
    logic [31:0] expAddr, expWdata, expRdata;
    bit          expWe;
    logic [3:0]  expBe;
    bit          ifGntSeen, dGntSeen;
    int          expIfWait, expDWait;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    task automatic clearModel();
        busy = 0; waitGnt = 0; waitRv = 0; ownIf = 0; drop = 0; streak = 0;
        rvDelay = -1; ifGntSeen = 0; dGntSeen = 0; expIfWait = 0; expDWait = 0;
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_if_gnt"}, if_gnt, 0);
        checkOutput({tag, "_d_gnt"}, d_gnt, 0);
        checkOutput({tag, "_if_rvalid"}, if_rvalid, 0);
        checkOutput({tag, "_d_rvalid"}, d_rvalid, 0);
        checkOutput({tag, "_if_rdata"}, if_rdata, 0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 0);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_mem_be"}, mem_be, 0);
`ifdef MEM_ARB_PERF_EN
        checkOutput({tag, "_perf_if"}, perf_if_wait, 0);
        checkOutput({tag, "_perf_d"}, perf_d_wait, 0);
`endif
    endtask

    // One clock cycle: drive requesters and memory, then check against the model.
    task automatic applyStimulus(input int pIf, input int pD, input int pFlush,
                                 input int pGnt, input int rvMax);
        bit expIfG, expDG, expMemReq, expIfRv, expDRv, ifWant;
        @(posedge clk); #1;
        if (ifGntSeen) if_req = 0;
        if (!if_req && ($urandom_range(99) < pIf)) begin
            if_req  = 1;
            if_addr = 32'($urandom_range(15)) << 2;
        end
        if (dGntSeen) d_req = 0;
        if (!d_req && ($urandom_range(99) < pD)) begin
            d_req   = 1;
            d_we    = 1'($urandom_range(1));
            d_addr  = 32'($urandom_range(15)) << 2;
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(15));
        end
        if_flush   = ($urandom_range(99) < pFlush);
        mem_gnt    = 0;
        mem_rvalid = 0;
        if (rvDelay == 0) begin
            mem_rvalid = 1;
            mem_rdata  = memRd;
            rvDelay    = -1;
        end else if (rvDelay > 0) begin
            rvDelay--;
        end
        if (mem_req && rvDelay < 0 && !mem_rvalid && ($urandom_range(99) < pGnt)) begin
            mem_gnt = 1;
            if (mem_we) memArr[idx(mem_addr)] = mergeBe(memArr[idx(mem_addr)], mem_wdata, mem_be);
            memRd   = memArr[idx(mem_addr)];
            rvDelay = $urandom_range(rvMax);
        end

        @(negedge clk);
        expIfG = 0;
        expDG  = 0;
        if (!busy) begin
            ifWant = if_req && !if_flush;
            if (ifWant && (!d_req || streak == MAXS)) expIfG = 1;
            else if (d_req) expDG = 1;
        end
        checkOutput("if_gnt", if_gnt, expIfG);
        checkOutput("d_gnt", d_gnt, expDG);
        expMemReq = busy && waitGnt;
        checkOutput("mem_req", mem_req, expMemReq);
        if (expMemReq) begin
            checkOutput("mem_addr", mem_addr, expAddr);
            checkOutput("mem_we", mem_we, expWe);
            if (expWe) begin
                checkOutput("mem_be", mem_be, expBe);
                checkOutput("mem_wdata", mem_wdata, expWdata);
            end
        end
        expIfRv = busy && waitRv && mem_rvalid && ownIf && !(drop || if_flush);
        expDRv  = busy && waitRv && mem_rvalid && !ownIf;
        checkOutput("if_rvalid", if_rvalid, expIfRv);
        checkOutput("d_rvalid", d_rvalid, expDRv);
        if (expIfRv) checkOutput("if_rdata", if_rdata, expRdata);
        if (expDRv && !expWe) checkOutput("d_rdata", d_rdata, expRdata);
`ifdef MEM_ARB_PERF_EN
        checkOutput("perf_if_wait", perf_if_wait, expIfWait);
        checkOutput("perf_d_wait", perf_d_wait, expDWait);
`endif
        expIfWait += (if_req && !expIfG) ? 1 : 0;
        expDWait  += (d_req && !expDG) ? 1 : 0;

        if (busy) begin
            if (waitGnt) begin
                if (ownIf && if_flush && !mem_gnt) begin
                    busy = 0;
                end else begin
                    if (ownIf && if_flush) drop = 1;
                    if (mem_gnt) begin waitGnt = 0; waitRv = 1; end
                end
            end else begin
                if (ownIf && if_flush) drop = 1;
                if (mem_rvalid) busy = 0;
            end
        end else if (expIfG) begin
            busy = 1; waitGnt = 1; waitRv = 0; ownIf = 1; drop = 0;
            expAddr = if_addr; expWe = 0; expRdata = refMem[idx(if_addr)];
            streak = 0;
        end else if (expDG) begin
            busy = 1; waitGnt = 1; waitRv = 0; ownIf = 0; drop = 0;
            expAddr = d_addr; expWe = d_we; expBe = d_be; expWdata = d_wdata;
            if (d_we) refMem[idx(d_addr)] = mergeBe(refMem[idx(d_addr)], d_wdata, d_be);
            else expRdata = refMem[idx(d_addr)];
            streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end
        ifGntSeen = if_gnt;
        dGntSeen  = d_gnt;
    endtask

    task automatic resetInWait();
        bit reached;
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            applyStimulus(100, 0, 0, 100, 3);
            reached = busy && waitRv;
        end
        checkOutput("reach_wait", reached, 1);
        @(posedge clk); #1;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        if_req = 1; d_req = 1;
        reset = 0;
        #1;
        checkResetOutputs("rst_wait");
        clearModel();
        @(negedge clk);
        checkResetOutputs("rst_hold");
        @(posedge clk); #1;
        reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            memArr[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            refMem[i] = memArr[i];
        end
        memRd = '0;
        clearModel();
        reset  = 0;
        if_req = 1;
        d_req  = 1;
        repeat (2) @(negedge clk);
        checkResetOutputs("rst_init");
        if_req = 0;
        d_req  = 0;
        @(posedge clk); #1;
        reset = 1;

        $display("[TB] fetch-only, immediate memory");
        repeat (40) applyStimulus(100, 0, 0, 100, 0);
        $display("[TB] continuous fetch and data, streak limit");
        repeat (200) applyStimulus(100, 100, 0, 100, 0);
        $display("[TB] random traffic with flushes and memory stalls");
        repeat (2000) applyStimulus(50, 50, 10, 60, 3);
        $display("[TB] reset during WAIT");
        resetInWait();
        repeat (300) applyStimulus(60, 40, 5, 70, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
